// File: rtl/cic3_interp32_pkg.sv
// Shared constants and types for the three-stage R=32 CIC interpolator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cic3_interp32_pkg;

    // Rate change, stage count and log2 of the rate change.
    localparam int R     = 32;
    localparam int N     = 3;
    localparam int LOG2R = 5;

    // Datapath widths. Each comb grows by one bit. The integrators carry
    // 10 input bits plus 10 bits of growth, because (R*M)^N / R = 1024.
    localparam int IN_W  = 10;
    localparam int C1_W  = 11;
    localparam int C2_W  = 12;
    localparam int C3_W  = 13;
    localparam int INT_W = 20;
    localparam int OUT_W = 10;

    // Rate-control state. The comb chain advances only in ST_SAMPLE.
    typedef enum logic {
        ST_HOLD   = 1'b0,
        ST_SAMPLE = 1'b1
    } state_t;

endpackage

// File: rtl/cic3_interp32_if.sv
// Sample bus between the upstream source and the interpolator.
// Latency: n/a (wiring only).
// Backpressure: none; the source must present x_in during the clk2 cycle.
interface cic3_interp32_if;
    import cic3_interp32_pkg::*;

    logic                    clk2;
    logic signed [IN_W-1:0]  x_in;
    logic signed [OUT_W-1:0] y_out;

    // The source drives samples and watches the load strobe.
    modport master (
        output x_in,
        input  clk2,
        input  y_out
    );

    // The interpolator consumes samples and issues the strobe.
    modport slave (
        input  x_in,
        output clk2,
        output y_out
    );

endinterface

// File: rtl/cic_rate_ctl.sv
// Rate controller: a 5-bit wrap counter producing a one-in-32 sample state and strobe.
// Latency: clk2 and state are registered and rise in the cycle after the count==31 edge.
// Backpressure: none; free-running from reset.
module cic_rate_ctl
    import cic3_interp32_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    output state_t state,
    output logic   clk2
);

    logic [LOG2R-1:0] count;

    // Counter wraps 0..31; the wrap edge opens a single-cycle sample window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            state <= ST_HOLD;
            clk2  <= 1'b0;
        end else if (count == LOG2R'(R - 1)) begin
            count <= '0;
            state <= ST_SAMPLE;
            clk2  <= 1'b1;
        end else begin
            count <= count + LOG2R'(1);
            state <= ST_HOLD;
            clk2  <= 1'b0;
        end
    end

endmodule

// File: rtl/cic3_interp32.sv
// Three-stage CIC interpolator: R=32, M=1, with unity DC gain taken from i3[19:10].
// Latency: 4 sample periods + 2 clks (130 clks) from a capture edge to its first effect on i3/y_out.
// Backpressure: none; x_in is captured on the edge that ends each clk2 cycle.
module cic3_interp32
    import cic3_interp32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    cic3_interp32_if.slave  bus
);

    state_t state;
    logic   clk2_r;

    logic signed [IN_W-1:0]  c0;
    logic signed [IN_W-1:0]  d0;
    logic signed [C1_W-1:0]  c1;
    logic signed [C1_W-1:0]  d1;
    logic signed [C2_W-1:0]  c2;
    logic signed [C2_W-1:0]  d2;
    logic signed [C3_W-1:0]  c3;

    logic signed [INT_W-1:0] u;
    logic signed [INT_W-1:0] i1;
    logic signed [INT_W-1:0] i2;
    logic signed [INT_W-1:0] i3;

    cic_rate_ctl u_rate_ctl (
        .clk   (clk),
        .reset (reset),
        .state (state),
        .clk2  (clk2_r)
    );

    assign bus.clk2 = clk2_r;

    // Low-rate comb chain: full-width differences, one bit of growth per stage, so no overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c0 <= '0;
            d0 <= '0;
            c1 <= '0;
            d1 <= '0;
            c2 <= '0;
            d2 <= '0;
            c3 <= '0;
        end else if (state == ST_SAMPLE) begin
            c0 <= bus.x_in;
            d0 <= c0;
            c1 <= C1_W'(c0) - C1_W'(d0);
            d1 <= c1;
            c2 <= C2_W'(c1) - C2_W'(d1);
            d2 <= c2;
            c3 <= C3_W'(c2) - C3_W'(d2);
        end
    end

    // Zero-stuffing: the comb output is injected for one clk per sample period, and zero otherwise.
    always_comb begin
        u = '0;
        if (state == ST_SAMPLE) begin
            u = INT_W'(c3);
        end
    end

    // Full-rate integrators. Two's-complement wrap is harmless: the result is exact modulo 2^20.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
        end else begin
            i1 <= i1 + u;
            i2 <= i2 + i1;
            i3 <= i3 + i2;
        end
    end

    // Dropping the 10 growth bits (truncation, no rounding) restores unity DC gain.
    assign bus.y_out = i3[INT_W-1:INT_W-OUT_W];

endmodule

// File: tb/tb_cic3_interp32.sv
// Directed bench for cic3_interp32. The expected output comes from a direct-form
// convolution model: a zero-stuffed input convolved with three 32-tap boxcars.
// Hand-derived constants cover latency, peak, support length and the settled values.
module tb_cic3_interp32;

    logic clk;
    logic reset;

    cic3_interp32_if bus ();

    cic3_interp32 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Impulse response of (1 + z^-1 + ... + z^-31)^3: 94 taps summing to 32768.
    int h [94];
    int cap_edge [$];
    int cap_val  [$];

    logic signed [9:0] x_cur;
    logic              sum_en;
    int                isum;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Full-precision output after edge e, i.e. the value that i3 must hold.
    function automatic int model_full(input int e);
        int acc;
        acc = 0;
        for (int i = 0; i < cap_edge.size(); i++) begin
            int n;
            n = e - cap_edge[i] - 130;
            if (n >= 0 && n < 94) acc += cap_val[i] * h[n];
        end
        return acc;
    endfunction

    // One clock out of reset: record captures and check the strobe and output against the model.
    task automatic tick();
        int exp_y;
        @(posedge clk);
        cyc++;
        if (cyc >= 33 && (cyc % 32) == 1) begin
            cap_edge.push_back(cyc);
            cap_val.push_back(int'(bus.x_in));
        end
        @(negedge clk);
        check("clk2", bus.clk2, (cyc >= 32 && (cyc % 32) == 0) ? 1 : 0);
        exp_y = model_full(cyc) >>> 10;
        check("y_out", $signed(bus.y_out), exp_y);
        if (sum_en) isum += int'(dut.i3);
        bus.x_in = x_cur;
    endtask

    // One clock in reset: the outputs must stay at zero whatever x_in does.
    task automatic reset_tick();
        @(posedge clk);
        @(negedge clk);
        check("rst_y_out", $signed(bus.y_out), 0);
        check("rst_clk2", bus.clk2, 0);
        bus.x_in = 10'($urandom);
    endtask

    // Release happens at a negedge, so the next posedge is edge 1.
    task automatic release_reset();
        reset = 1'b0;
        cyc   = 0;
        cap_edge.delete();
        cap_val.delete();
        bus.x_in = x_cur;
    endtask

    initial begin
        int h2 [63];
        int ymax;
        int yprev;
        int rises;
        int nz_cnt;
        int first_nz;
        int imp_edge;
        int found;

        // Build the reference impulse response by explicit convolution.
        for (int n = 0; n < 63; n++) begin
            h2[n] = 0;
            for (int j = 0; j < 32; j++)
                if (n - j >= 0 && n - j < 32) h2[n] += 1;
        end
        for (int n = 0; n < 94; n++) begin
            h[n] = 0;
            for (int j = 0; j < 32; j++)
                if (n - j >= 0 && n - j < 63) h[n] += h2[n - j];
        end

        sum_en   = 1'b0;
        isum     = 0;
        x_cur    = '0;
        bus.x_in = '0;
        reset    = 1'b1;

        // Reset, then DC +256.
        x_cur = 10'sd256;
        repeat (5) reset_tick();
        release_reset();
        while (cyc < 162) tick();
        check("i3_before_first", dut.i3, 0);
        tick();
        check("i3_first_nonzero", dut.i3, 256);
        ymax = 0;
        while (cyc < 450) begin
            tick();
            if (int'($signed(bus.y_out)) > ymax) ymax = int'($signed(bus.y_out));
        end
        check("dc256_settled", $signed(bus.y_out), 256);
        check("dc256_no_overshoot", ymax, 256);

        // Full-scale negative DC: the integrators wrap internally, but the output must not.
        x_cur = -10'sd512;
        repeat (300) tick();
        check("dc_neg512", $signed(bus.y_out), -512);

        // Step from +100 to -100: the output must never rise.
        x_cur = 10'sd100;
        repeat (300) tick();
        check("dc100", $signed(bus.y_out), 100);
        x_cur = -10'sd100;
        rises = 0;
        yprev = int'($signed(bus.y_out));
        repeat (250) begin
            tick();
            if (int'($signed(bus.y_out)) > yprev) rises++;
            yprev = int'($signed(bus.y_out));
        end
        check("step_monotonic_rises", rises, 0);
        check("step_neg100", $signed(bus.y_out), -100);

        // Impulse of 511. The first nonzero output tap is h(1)=3 (511*3 >= 1024), the last is h(92).
        // The peak is 511*768/1024, which truncates to 383.
        x_cur = '0;
        repeat (300) tick();
        check("zero_settled", $signed(bus.y_out), 0);
        check("zero_i3", dut.i3, 0);
        x_cur = 10'sd511;
        found = 0;
        for (int k = 0; k < 70 && found == 0; k++) begin
            tick();
            if (cap_val.size() > 0 && cap_val[cap_val.size() - 1] == 511) found = 1;
        end
        check("impulse_captured", found, 1);
        imp_edge = (cap_edge.size() > 0) ? cap_edge[cap_edge.size() - 1] : 0;
        x_cur    = '0;
        sum_en   = 1'b1;
        isum     = 0;
        ymax     = 0;
        nz_cnt   = 0;
        first_nz = -1;
        repeat (260) begin
            tick();
            if (bus.y_out != '0) begin
                nz_cnt++;
                if (first_nz < 0) first_nz = cyc - imp_edge;
            end
            if (int'($signed(bus.y_out)) > ymax) ymax = int'($signed(bus.y_out));
        end
        sum_en = 1'b0;
        check("impulse_i3_sum", isum, 511 * 32768);
        check("impulse_peak", ymax, 383);
        check("impulse_nonzero_len", nz_cnt, 92);
        check("impulse_first_nz_ofs", first_nz, 131);
        check("impulse_tail_zero", $signed(bus.y_out), 0);

        // Reset mid-stream at count 17 during DC +256: the outputs must clear without waiting for a clock.
        x_cur = 10'sd256;
        repeat (300) tick();
        check("pre_reset_dc256", $signed(bus.y_out), 256);
        while ((cyc % 32) != 17) tick();
        reset = 1'b1;
        #1;
        check("async_rst_y_out", $signed(bus.y_out), 0);
        check("async_rst_clk2", bus.clk2, 0);
        check("async_rst_i3", dut.i3, 0);
        repeat (4) reset_tick();
        release_reset();
        while (cyc < 162) tick();
        check("rst2_i3_before_first", dut.i3, 0);
        tick();
        check("rst2_i3_first_nonzero", dut.i3, 256);
        while (cyc < 263) tick();
        check("rst2_dc256_settled", $signed(bus.y_out), 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
